ula_arbiter: RTL and testbench
==============================

# ula_arbiter

Sequencer and two-port arbiter for the shared 4-bit ALU (`ULA_Desafio`) in the MIPS sprint datapath. Two requesters each present operands and an operation select through a valid/ready handshake. The block grants one request at a time using round-robin, drives the ALU from registered operands, and captures the ALU result. It then returns the result, tagged with the requester id, through a valid/ready response port. It sits between the switch/control logic and the ALU instance in the board top.

## Interface
- `WIDTH`, 4, operand/result width
- `SELW`, 2, ALU operation-select width
- `CNTW`, 8, width of completed-operation counter
- `iCLK`  in  1  system clock (CLOCK_50 domain)
- `iRST`  in  1  asynchronous, active-high reset
- `req0_valid`, `req1_valid`  in  1  request present
- `req0_a`, `req1_a`  in  WIDTH  operand A
- `req0_b`, `req1_b`  in  WIDTH  operand B
- `req0_sel`, `req1_sel`  in  SELW  ALU operation
- `req0_ready`, `req1_ready`  out  1  request accepted this cycle
- `alu_a`  out  WIDTH  to ALU `.a`
- `alu_b`  out  WIDTH  to ALU `.b`
- `alu_sel`  out  SELW  to ALU `.sel`
- `alu_saida`  in  WIDTH  ALU combinational result
- `rsp_valid`  out  1  response present
- `rsp_id`  out  1  requester that owns response (0/1)
- `rsp_data`  out  WIDTH  captured ALU result
- `rsp_ready`  in  1  consumer accepts response
- `busy`  out  1  state != IDLE
- `done_cnt`  out  CNTW  completed responses, wraps

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE**
  - The winner is chosen combinationally.
    - Only one valid: that one wins.
    - Both valid: the requester not equal to `last_grant` wins.
  - `reqN_ready` = (state==IDLE) && winner==N. At most one ready is high per cycle.
  - On handshake (valid && ready):
    - latch a/b/sel into op registers;
    - `rsp_id` <= N;
    - `last_grant` <= N;
    - go to EXEC.
  - With no valid request, stay in IDLE.
- **EXEC**
  - `alu_a`/`alu_b`/`alu_sel` are the op registers. They are driven from registers only, never combinationally from requester ports.
  - At the end of the cycle: `rsp_data` <= `alu_saida`; go to RESP.
- **RESP**
  - `rsp_valid`=1. `rsp_data` and `rsp_id` are held stable.
  - On `rsp_ready`=1:
    - `done_cnt` += 1 (wraps 2^CNTW-1 -> 0);
    - go to IDLE.
  - Otherwise hold (backpressure, unbounded).
- Op registers keep their last values outside EXEC. The ALU inputs therefore stay stable and show the last operation.
- Requesters must hold valid/operands until ready. A valid deasserted before ready is simply not served; there is no error.
- Reset values (asynchronous, on `iRST`=1):
  - state=IDLE;
  - op regs, `alu_a`, `alu_b`, `alu_sel` = 0;
  - `rsp_valid`=0, `rsp_data`=0, `rsp_id`=0;
  - `last_grant`=1, so requester 0 wins the first contention;
  - `done_cnt`=0, `busy`=0;
  - both readies 0 while reset is asserted.
- Reset mid-operation (EXEC or RESP) aborts the operation. The response is discarded and `done_cnt` is not incremented.

## Timing
- Request accepted at rising edge E0 (IDLE, valid&&ready).
- ALU inputs are valid during E0..E1. The result is captured at E1.
- `rsp_valid` is high from after E1. The earliest response handshake is at E2.
- The earliest next accept is at E3. Peak throughput is 1 op / 3 cycles with `rsp_ready` tied high.
- `busy` is high from after E0 until the cycle after the response handshake.
- The ALU is combinational with a single-cycle path from op regs to `rsp_data`. No multicycle constraint applies.

## Test plan
- Bench ALU model: sel 00 a+b, 01 a-b, 10 a&b, 11 a|b, all mod 16.
- **Reset defaults:** assert `iRST` mid-cycle with no clock edge -> all outputs 0, `busy`=0 immediately.
- **Single request:** req0 a=3 b=5 sel=00, `rsp_ready`=1 -> `req0_ready` at E0; `rsp_valid` after E1 with `rsp_data`=8 (4'h8), `rsp_id`=0; `done_cnt`=1.
- **Contention / round-robin:** req0 (a=9 b=4 sel=01) and req1 (a=6 b=3 sel=11) held valid from reset -> req0 served first (`rsp_data`=5, id 0), then req1 (`rsp_data`=7, id 1), then req0 again if still valid. The two readies are never high together.
- **Backpressure:** `rsp_ready`=0 for 10 cycles on response 4'hF (a=15 b=0 sel=11) -> `rsp_valid`, `rsp_data`=F, `rsp_id` stable; both readies low; accept resumes 1 cycle after `rsp_ready` rises.
- **Wrap arithmetic and counter:** 256 back-to-back ops including a=15 b=1 sel=00 -> `rsp_data`=0; a=0 b=1 sel=01 -> `rsp_data`=F; `done_cnt` returns to 0 after the 256th response.
- **Reset mid-op:** assert `iRST` during EXEC of req1 -> `rsp_valid` never rises for that op; `done_cnt` unchanged (0); after release, pending req0 and req1 -> req0 granted first.

Source files
------------

// File: rtl/ula_arbiter.sv
// ---------------------------------------------------------------------------
// ula_arbiter
//
// Purpose:
//   Sequencer and two-port round-robin arbiter for the shared combinational
//   ALU (ULA_Desafio). It accepts one request at a time, drives the ALU from
//   registered operands, captures the result and returns it with the owner's
//   id through a valid/ready response port.
//
// Ports:
//   iCLK, iRST                 clock, asynchronous active-high reset
//   reqN_valid/a/b/sel         request N (N = 0, 1) handshake and operands
//   reqN_ready                 request N accepted this cycle
//   alu_a, alu_b, alu_sel      registered operands to the ALU
//   alu_saida                  combinational ALU result
//   rsp_valid/id/data          response handshake, owner id, captured result
//   rsp_ready                  consumer accepts the response
//   busy                       FSM is not idle
//   done_cnt                   completed responses, wraps
//
// States:
//   state  | meaning
//   S_IDLE | waiting for a request; winner chosen combinationally
//   S_EXEC | operands on the ALU, result captured at end of cycle
//   S_RESP | response presented until rsp_ready
// ---------------------------------------------------------------------------
module ula_arbiter #(
    parameter int WIDTH = 4,
    parameter int SELW  = 2,
    parameter int CNTW  = 8
) (
    input  logic             iCLK,
    input  logic             iRST,

    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [SELW-1:0]  req0_sel,
    output logic             req0_ready,

    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [SELW-1:0]  req1_sel,
    output logic             req1_ready,

    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [SELW-1:0]  alu_sel,
    input  logic [WIDTH-1:0] alu_saida,

    output logic             rsp_valid,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    input  logic             rsp_ready,

    output logic             busy,
    output logic [CNTW-1:0]  done_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_RESP = 2'b10
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] op_a_q;
    logic [WIDTH-1:0] op_b_q;
    logic [SELW-1:0]  op_sel_q;
    logic             rsp_valid_q;
    logic             rsp_id_q;
    logic [WIDTH-1:0] rsp_data_q;
    logic             last_grant_q;
    logic [CNTW-1:0]  done_cnt_q;
    logic             busy_q;

    logic             grant_vld_d;
    logic             grant_id_d;
    logic [WIDTH-1:0] grant_a_d;
    logic [WIDTH-1:0] grant_b_d;
    logic [SELW-1:0]  grant_sel_d;
    logic             accept_d;

    // Winner selection: a lone requester wins; on contention the one that
    // was not granted last time wins.
    always_comb begin
        grant_vld_d = req0_valid || req1_valid;
        grant_id_d  = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_id_d = ~last_grant_q;
        end else if (req1_valid) begin
            grant_id_d = 1'b1;
        end
    end

    always_comb begin
        grant_a_d   = grant_id_d ? req1_a   : req0_a;
        grant_b_d   = grant_id_d ? req1_b   : req0_b;
        grant_sel_d = grant_id_d ? req1_sel : req0_sel;
    end

    // Readies are forced low while reset is held, since the state register
    // already reads IDLE during reset.
    always_comb begin
        accept_d   = (state_q == S_IDLE) && grant_vld_d && !iRST;
        req0_ready = accept_d && (grant_id_d == 1'b0);
        req1_ready = accept_d && (grant_id_d == 1'b1);
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q      <= S_IDLE;
            op_a_q       <= '0;
            op_b_q       <= '0;
            op_sel_q     <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_data_q   <= '0;
            last_grant_q <= 1'b1;
            done_cnt_q   <= '0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept_d) begin
                        op_a_q       <= grant_a_d;
                        op_b_q       <= grant_b_d;
                        op_sel_q     <= grant_sel_d;
                        rsp_id_q     <= grant_id_d;
                        last_grant_q <= grant_id_d;
                        busy_q       <= 1'b1;
                        state_q      <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    rsp_data_q  <= alu_saida;
                    rsp_valid_q <= 1'b1;
                    state_q     <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        done_cnt_q  <= done_cnt_q + CNTW'(1);
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    // ALU inputs come straight from the op registers so they hold the last
    // operation outside EXEC and never follow the requester ports.
    assign alu_a     = op_a_q;
    assign alu_b     = op_b_q;
    assign alu_sel   = op_sel_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = busy_q;
    assign done_cnt  = done_cnt_q;

endmodule

// File: tb/tb_ula_arbiter.sv
module tb_ula_arbiter;

    logic       iCLK = 1'b0;
    logic       iRST;
    logic       req0_valid, req1_valid;
    logic [3:0] req0_a, req0_b, req1_a, req1_b;
    logic [1:0] req0_sel, req1_sel;
    logic       req0_ready, req1_ready;
    logic [3:0] alu_a, alu_b, alu_saida;
    logic [1:0] alu_sel;
    logic       rsp_valid, rsp_id, rsp_ready;
    logic [3:0] rsp_data;
    logic       busy;
    logic [7:0] done_cnt;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_cnt;
    logic       mon_en = 1'b0;

    always #5 iCLK = ~iCLK;

    ula_arbiter #(.WIDTH(4), .SELW(2), .CNTW(8)) dut (
        .iCLK       (iCLK),
        .iRST       (iRST),
        .req0_valid (req0_valid),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_sel   (req0_sel),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_sel   (req1_sel),
        .req1_ready (req1_ready),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_sel    (alu_sel),
        .alu_saida  (alu_saida),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_ready  (rsp_ready),
        .busy       (busy),
        .done_cnt   (done_cnt)
    );

    function automatic logic [3:0] alu_f(input logic [3:0] a, input logic [3:0] b,
                                         input logic [1:0] s);
        case (s)
            2'b00:   return a + b;
            2'b01:   return a - b;
            2'b10:   return a & b;
            default: return a | b;
        endcase
    endfunction

    assign alu_saida = alu_f(alu_a, alu_b, alu_sel);

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    always @(negedge iCLK) begin
        if (mon_en) chk("rdy_excl", {31'd0, req0_ready & req1_ready}, 32'd0);
    end

    // Called at a negedge in IDLE with requests already driven and
    // rsp_ready=1; returns at the negedge after the response handshake.
    task automatic run_op(input logic id, input logic [3:0] data);
        #1;
        chk("rdy_win",  {31'd0, id ? req1_ready : req0_ready}, 32'd1);
        chk("rdy_lose", {31'd0, id ? req0_ready : req1_ready}, 32'd0);
        @(negedge iCLK);
        chk("exec_busy", {31'd0, busy}, 32'd1);
        chk("exec_rv",   {31'd0, rsp_valid}, 32'd0);
        @(negedge iCLK);
        chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("rsp_data",  {28'd0, rsp_data}, {28'd0, data});
        chk("rsp_id",    {31'd0, rsp_id}, {31'd0, id});
        @(negedge iCLK);
        exp_cnt = exp_cnt + 8'd1;
        chk("done_cnt",  {24'd0, done_cnt}, {24'd0, exp_cnt});
        chk("idle_rv",   {31'd0, rsp_valid}, 32'd0);
        chk("idle_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] ta, tb2;
        logic [1:0] ts;
        exp_cnt    = 8'd0;
        iRST       = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = 4'd0; req0_b = 4'd0; req0_sel = 2'd0;
        req1_a = 4'd0; req1_b = 4'd0; req1_sel = 2'd0;
        rsp_ready  = 1'b1;
        @(negedge iCLK);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_rv",   {31'd0, rsp_valid}, 32'd0);
        chk("rst_cnt",  {24'd0, done_cnt}, 32'd0);
        @(negedge iCLK);
        iRST   = 1'b0;
        mon_en = 1'b1;

        // Single request: 3 + 5 = 8
        req0_valid = 1'b1; req0_a = 4'd3; req0_b = 4'd5; req0_sel = 2'b00;
        #1;
        chk("s_rdy0", {31'd0, req0_ready}, 32'd1);
        chk("s_rdy1", {31'd0, req1_ready}, 32'd0);
        @(negedge iCLK);
        chk("s_alu_a", {28'd0, alu_a}, 32'd3);
        chk("s_alu_b", {28'd0, alu_b}, 32'd5);
        chk("s_busy",  {31'd0, busy}, 32'd1);
        chk("s_rdy_x", {31'd0, req0_ready}, 32'd0);
        req0_valid = 1'b0;
        @(negedge iCLK);
        chk("s_rv",   {31'd0, rsp_valid}, 32'd1);
        chk("s_data", {28'd0, rsp_data}, 32'h8);
        chk("s_id",   {31'd0, rsp_id}, 32'd0);
        @(negedge iCLK);
        chk("s_cnt",  {24'd0, done_cnt}, 32'd1);
        chk("s_idle", {31'd0, busy}, 32'd0);
        chk("s_hold_a", {28'd0, alu_a}, 32'd3);

        // Mid-cycle reset, no clock edge; contention requests held from reset
        #2;
        iRST = 1'b1;
        req0_valid = 1'b1; req0_a = 4'd9; req0_b = 4'd4; req0_sel = 2'b01;
        req1_valid = 1'b1; req1_a = 4'd6; req1_b = 4'd3; req1_sel = 2'b11;
        #1;
        chk("mr_alu_a",  {28'd0, alu_a}, 32'd0);
        chk("mr_alu_b",  {28'd0, alu_b}, 32'd0);
        chk("mr_alu_s",  {30'd0, alu_sel}, 32'd0);
        chk("mr_rv",     {31'd0, rsp_valid}, 32'd0);
        chk("mr_data",   {28'd0, rsp_data}, 32'd0);
        chk("mr_id",     {31'd0, rsp_id}, 32'd0);
        chk("mr_cnt",    {24'd0, done_cnt}, 32'd0);
        chk("mr_busy",   {31'd0, busy}, 32'd0);
        chk("mr_rdy0",   {31'd0, req0_ready}, 32'd0);
        chk("mr_rdy1",   {31'd0, req1_ready}, 32'd0);
        exp_cnt = 8'd0;
        @(negedge iCLK);
        iRST = 1'b0;

        // Round-robin: 9-4=5 (id0), 6|3=7 (id1), 5 (id0)
        run_op(1'b0, 4'h5);
        run_op(1'b1, 4'h7);
        run_op(1'b0, 4'h5);

        // Backpressure on 15|0 = F from req1 (req1 wins after req0)
        req1_a = 4'd15; req1_b = 4'd0; req1_sel = 2'b11;
        req0_a = 4'd1;  req0_b = 4'd1; req0_sel = 2'b00;
        rsp_ready = 1'b0;
        #1;
        chk("bp_rdy1", {31'd0, req1_ready}, 32'd1);
        chk("bp_rdy0", {31'd0, req0_ready}, 32'd0);
        @(negedge iCLK);
        @(negedge iCLK);
        for (int i = 0; i < 10; i++) begin
            chk("bp_rv",   {31'd0, rsp_valid}, 32'd1);
            chk("bp_data", {28'd0, rsp_data}, 32'hF);
            chk("bp_id",   {31'd0, rsp_id}, 32'd1);
            chk("bp_rdy0", {31'd0, req0_ready}, 32'd0);
            chk("bp_rdy1", {31'd0, req1_ready}, 32'd0);
            chk("bp_cnt",  {24'd0, done_cnt}, 32'd3);
            @(negedge iCLK);
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_rv_last", {31'd0, rsp_valid}, 32'd1);
        @(negedge iCLK);
        exp_cnt = exp_cnt + 8'd1;
        chk("bp_cnt_inc", {24'd0, done_cnt}, {24'd0, exp_cnt});
        chk("bp_idle",    {31'd0, busy}, 32'd0);
        run_op(1'b0, 4'h2);

        // Reset during EXEC of req1
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_a = 4'd6; req1_b = 4'd3; req1_sel = 2'b11;
        #1;
        chk("ro_rdy1", {31'd0, req1_ready}, 32'd1);
        @(negedge iCLK);
        chk("ro_exec", {31'd0, busy}, 32'd1);
        #2;
        iRST = 1'b1;
        req0_valid = 1'b1; req0_a = 4'd9; req0_b = 4'd4; req0_sel = 2'b01;
        #1;
        chk("ro_rv",   {31'd0, rsp_valid}, 32'd0);
        chk("ro_busy", {31'd0, busy}, 32'd0);
        chk("ro_cnt",  {24'd0, done_cnt}, 32'd0);
        exp_cnt = 8'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge iCLK);
            chk("ro_rv_hold", {31'd0, rsp_valid}, 32'd0);
        end
        iRST = 1'b0;
        run_op(1'b0, 4'h5);
        run_op(1'b1, 4'h7);

        // 256 back-to-back ops from req0 with wrap arithmetic and counter wrap
        req1_valid = 1'b0;
        @(negedge iCLK);
        iRST = 1'b1;
        @(negedge iCLK);
        iRST = 1'b0;
        exp_cnt = 8'd0;
        for (int i = 0; i < 256; i++) begin
            if (i == 0) begin
                ta = 4'd15; tb2 = 4'd1; ts = 2'b00;
                req0_a = ta; req0_b = tb2; req0_sel = ts;
                run_op(1'b0, 4'h0);
            end else if (i == 1) begin
                ta = 4'd0; tb2 = 4'd1; ts = 2'b01;
                req0_a = ta; req0_b = tb2; req0_sel = ts;
                run_op(1'b0, 4'hF);
            end else begin
                ta = 4'(i); tb2 = 4'(i >> 4); ts = 2'(i >> 2);
                req0_a = ta; req0_b = tb2; req0_sel = ts;
                run_op(1'b0, alu_f(ta, tb2, ts));
            end
        end
        chk("cnt_wrap", {24'd0, done_cnt}, 32'd0);
        req0_valid = 1'b0;
        mon_en = 1'b0;
        @(negedge iCLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
